// File: rtl/key_input_conditioner.sv
// Two-button front end: synchronise, debounce and arbitrate raw keys into single-cycle pulses.
// Define KEY_STUCK_DETECT_EN to build the stuck-key hold counter behind key_stuck.
module key_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned STUCK_CYCLES    = 50000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn0,
    input  logic btn1,
    output logic key0_pulse,
    output logic key1_pulse,
    output logic key_conflict,
    output logic key_stuck
);

    localparam int unsigned HoldW = 26;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
        64'(DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_W) ||
        STUCK_CYCLES < 1 || 64'(STUCK_CYCLES) > (64'd1 << HoldW)) begin : g_param_check
        $fatal(1, "key_input_conditioner: illegal parameter combination");
    end

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHeld0,
        StHeld1,
        StChord
    } state_e;

    // Bit 0 is key 0, bit 1 is key 1 throughout.
    logic [1:0]            meta_q;
    logic [1:0]            sync_q;
    logic [1:0]            db_q, db_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    state_e                state_q, state_d;
    logic                  pulse0_q, pulse0_d;
    logic                  pulse1_q, pulse1_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {btn1, btn0};
            sync_q <= meta_q;
        end
    end

    // Any cycle where the synchronised level agrees with the debounced level restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int k = 0; k < 2; k++) begin
            if (sync_q[k] == db_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CntLast) begin
                db_d[k]  = sync_q[k];
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            db_q  <= '0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Pulses are only ever launched on leaving idle, so a held key or a chord cannot repeat one.
    always_comb begin
        state_d  = state_q;
        pulse0_d = 1'b0;
        pulse1_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (db_q[0] && db_q[1]) begin
                    state_d = StChord;
                end else if (db_q[0]) begin
                    state_d  = StHeld0;
                    pulse0_d = 1'b1;
                end else if (db_q[1]) begin
                    state_d  = StHeld1;
                    pulse1_d = 1'b1;
                end
            end
            StHeld0: begin
                if (db_q[1]) begin
                    state_d = StChord;
                end else if (!db_q[0]) begin
                    state_d = StIdle;
                end
            end
            StHeld1: begin
                if (db_q[0]) begin
                    state_d = StChord;
                end else if (!db_q[1]) begin
                    state_d = StIdle;
                end
            end
            StChord: begin
                if (db_q == 2'b00) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            pulse0_q <= 1'b0;
            pulse1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pulse0_q <= pulse0_d;
            pulse1_q <= pulse1_d;
        end
    end

    assign key0_pulse   = pulse0_q;
    assign key1_pulse   = pulse1_q;
    assign key_conflict = (state_q == StChord);

`ifdef KEY_STUCK_DETECT_EN
    localparam logic [HoldW-1:0] HoldLast = HoldW'(STUCK_CYCLES - 1);

    logic [HoldW-1:0] hold_q, hold_d;
    logic             stuck_q, stuck_d;

    // Hold counter saturates so a very long press cannot wrap and re-trigger.
    always_comb begin
        hold_d  = hold_q;
        stuck_d = stuck_q;
        if (state_q == StIdle) begin
            hold_d  = '0;
            stuck_d = 1'b0;
        end else begin
            if (hold_q != '1) begin
                hold_d = hold_q + 1'b1;
            end
            if (hold_q == HoldLast) begin
                stuck_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            stuck_q <= stuck_d;
        end
    end

    assign key_stuck = stuck_q;
`else
    assign key_stuck = 1'b0;
`endif

endmodule

// File: tb/tb_key_input_conditioner.sv
// Self-checking bench for key_input_conditioner: directed scenarios plus random key activity
// checked each cycle against a behavioural model of the press/chord rules.
module tb_key_input_conditioner;

    localparam int DB    = 4;
    localparam int STUCK = 20;

    localparam int MIdle  = 0;
    localparam int MHeld0 = 1;
    localparam int MHeld1 = 2;
    localparam int MChord = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic btn0  = 1'b0;
    logic btn1  = 1'b0;
    logic key0_pulse, key1_pulse, key_conflict, key_stuck;

    key_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (16),
        .STUCK_CYCLES   (STUCK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn0        (btn0),
        .btn1        (btn1),
        .key0_pulse  (key0_pulse),
        .key1_pulse  (key1_pulse),
        .key_conflict(key_conflict),
        .key_stuck   (key_stuck)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;
    int edge_n = 0;
    int n_p0 = 0, n_p1 = 0, n_stuck = 0;
    int p0_edge = 0, p1_edge = 0, stuck_edge = 0;
    logic stuck_prev = 1'b0;

    // Model: raw keys reach the debouncer two edges late; a debounced level flips once the
    // last DB synchronised samples all disagree with it.
    logic [1:0]    m_meta, m_sync, m_db;
    logic [DB-1:0] m_hist [2];
    int            m_mode, m_entered;
    logic          m_p0, m_p1, m_conf, m_stuck;

    task automatic model_reset();
        m_meta    = '0;
        m_sync    = '0;
        m_db      = '0;
        m_hist[0] = '0;
        m_hist[1] = '0;
        m_mode    = MIdle;
        m_entered = 0;
        m_p0      = 1'b0;
        m_p1      = 1'b0;
        m_conf    = 1'b0;
        m_stuck   = 1'b0;
    endtask

    task automatic model_edge(input logic [1:0] raw);
        logic [1:0] pre_db;
        int         pre_mode;
        int         held;
        pre_db   = m_db;
        pre_mode = m_mode;
        held     = edge_n - 1 - m_entered;
        m_p0 = (pre_mode == MIdle) && (pre_db == 2'b01);
        m_p1 = (pre_mode == MIdle) && (pre_db == 2'b10);
`ifdef KEY_STUCK_DETECT_EN
        m_stuck = (pre_mode != MIdle) && (held >= STUCK - 1);
`else
        m_stuck = 1'b0;
`endif
        if (pre_mode == MIdle) begin
            if (pre_db != 2'b00) begin
                m_entered = edge_n;
                m_mode = (pre_db == 2'b11) ? MChord : (pre_db == 2'b01) ? MHeld0 : MHeld1;
            end
        end else if (pre_db == 2'b00) begin
            m_mode = MIdle;
        end else if ((pre_mode == MHeld0 && pre_db[1]) || (pre_mode == MHeld1 && pre_db[0])) begin
            m_mode = MChord;
        end
        m_conf = (m_mode == MChord);
        for (int k = 0; k < 2; k++) begin
            m_hist[k] = {m_hist[k][DB-2:0], m_sync[k]};
            if (m_hist[k] == {DB{~m_db[k]}}) m_db[k] = ~m_db[k];
        end
        m_sync = m_meta;
        m_meta = raw;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b, expected %b (edge %0d)", tag, obs, exp, edge_n);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, exp, edge_n);
    endtask

    task automatic cyc(input logic b0, input logic b1);
        btn0 = b0;
        btn1 = b1;
        @(posedge clock);
        edge_n++;
        if (reset) model_edge({b1, b0});
        #1;
        check("key0_pulse", key0_pulse, m_p0);
        check("key1_pulse", key1_pulse, m_p1);
        check("key_conflict", key_conflict, m_conf);
        check("key_stuck", key_stuck, m_stuck);
        check("pulse_exclusive", key0_pulse & key1_pulse, 1'b0);
        if (key0_pulse) begin n_p0++; p0_edge = edge_n; end
        if (key1_pulse) begin n_p1++; p1_edge = edge_n; end
        if (key_stuck) n_stuck++;
        if (key_stuck && !stuck_prev) stuck_edge = edge_n;
        stuck_prev = key_stuck;
    endtask

    task automatic reset_async();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_key0_pulse", key0_pulse, 1'b0);
        check("rst_key1_pulse", key1_pulse, 1'b0);
        check("rst_key_conflict", key_conflict, 1'b0);
        check("rst_key_stuck", key_stuck, 1'b0);
    endtask

    initial begin
        int base, c0, c1, t, hi, lo;
        model_reset();

        // Reset held with both keys down, then released with key 0 still held.
        repeat (3) cyc(1'b1, 1'b1);
        reset = 1'b1;
        base = edge_n; c0 = n_p0; c1 = n_p1;
        repeat (12) cyc(1'b1, 1'b0);
        check_int("reset_release_pulses", n_p0 - c0, 1);
        check_int("reset_release_latency", p0_edge - base, 7);
        check_int("reset_release_no_key1", n_p1 - c1, 0);
        repeat (10) cyc(1'b0, 1'b0);

        // Clean press of key 0.
        base = edge_n; c0 = n_p0; c1 = n_p1;
        repeat (20) cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);
        check_int("clean_pulses", n_p0 - c0, 1);
        check_int("clean_latency", p0_edge - base, 7);
        check_int("clean_no_key1", n_p1 - c1, 0);

        // Bouncing key 1, then a stable press.
        c1 = n_p1; t = 0;
        while (t < 30) begin
            hi = $urandom_range(1, 3);
            lo = $urandom_range(1, 3);
            repeat (hi) cyc(1'b0, 1'b1);
            repeat (lo) cyc(1'b0, 1'b0);
            t += hi + lo;
        end
        check_int("bounce_no_pulse", n_p1 - c1, 0);
        base = edge_n;
        repeat (12) cyc(1'b0, 1'b1);
        check_int("bounce_final_pulses", n_p1 - c1, 1);
        check_int("bounce_final_latency", p1_edge - base, 7);
        repeat (10) cyc(1'b0, 1'b0);

        // Simultaneous chord.
        c0 = n_p0; c1 = n_p1;
        repeat (10) cyc(1'b1, 1'b1);
        check("chord_conflict_held", key_conflict, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        check("chord_conflict_releasing", key_conflict, 1'b1);
        repeat (7) cyc(1'b0, 1'b0);
        check("chord_conflict_cleared", key_conflict, 1'b0);
        check_int("chord_no_key0", n_p0 - c0, 0);
        check_int("chord_no_key1", n_p1 - c1, 0);
        base = edge_n;
        repeat (12) cyc(1'b0, 1'b1);
        check_int("after_chord_key1", n_p1 - c1, 1);
        check_int("after_chord_latency", p1_edge - base, 7);
        repeat (10) cyc(1'b0, 1'b0);

        // Late chord: key 0 pulse stands, key 1 never pulses.
        c0 = n_p0; c1 = n_p1;
        repeat (10) cyc(1'b1, 1'b0);
        check_int("late_chord_key0", n_p0 - c0, 1);
        repeat (10) cyc(1'b1, 1'b1);
        check("late_chord_conflict", key_conflict, 1'b1);
        check_int("late_chord_no_key1", n_p1 - c1, 0);
        repeat (10) cyc(1'b0, 1'b0);
        check("late_chord_idle", key_conflict, 1'b0);

        // Long hold of key 0.
        c0 = n_p0; n_stuck = 0;
        repeat (40) cyc(1'b1, 1'b0);
        check_int("hold_single_pulse", n_p0 - c0, 1);
`ifdef KEY_STUCK_DETECT_EN
        check("stuck_set", key_stuck, 1'b1);
        check_int("stuck_delay", stuck_edge - p0_edge, 20);
        repeat (7) cyc(1'b0, 1'b0);
        check("stuck_held_until_idle", key_stuck, 1'b1);
        cyc(1'b0, 1'b0);
        check("stuck_cleared", key_stuck, 1'b0);
`else
        repeat (8) cyc(1'b0, 1'b0);
        check_int("stuck_never", n_stuck, 0);
`endif
        repeat (4) cyc(1'b0, 1'b0);

        // Reset mid-press drops the pending pulse; the held key must debounce afresh.
        c0 = n_p0;
        repeat (6) cyc(1'b1, 1'b0);
        reset_async();
        repeat (3) cyc(1'b1, 1'b0);
        check_int("midpress_reset_no_pulse", n_p0 - c0, 0);
        reset = 1'b1;
        base = edge_n;
        repeat (12) cyc(1'b1, 1'b0);
        check_int("midpress_after_pulses", n_p0 - c0, 1);
        check_int("midpress_after_latency", p0_edge - base, 7);
        repeat (10) cyc(1'b0, 1'b0);

        // Random key activity with occasional resets.
        for (int s = 0; s < 120; s++) begin
            logic [1:0] b;
            int         len;
            if ($urandom_range(0, 19) == 0) begin
                reset_async();
                repeat (2) cyc(btn0, btn1);
                reset = 1'b1;
            end else begin
                b   = 2'($urandom_range(0, 3));
                len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
                repeat (len) cyc(b[0], b[1]);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/key_input_conditioner.md
Name: key_input_conditioner

Overview:
- Front-end stage for the sequence-lock FSM.
- Takes the two raw, asynchronous, bouncing push-buttons and synchronises and debounces each one.
- Arbitrates simultaneous presses, then emits clean single-cycle press pulses that drive the lock's two key inputs directly.
- Chorded presses (both keys down together) are rejected so the lock never sees an ambiguous symbol.

Parameters:
- DEBOUNCE_CYCLES, 1000: consecutive cycles a synchronised key level must differ from the debounced level before the debounced level flips; legal range 1..65535.
- CNT_W, 16: width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
- STUCK_CYCLES, 50000000: hold time that flags a stuck key. Used only with KEY_STUCK_DETECT_EN.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn0  input  1  raw key "0", active-high, asynchronous to clock.
- btn1  input  1  raw key "1", active-high, asynchronous to clock.
- key0_pulse  output  1  one-cycle pulse per accepted key-0 press; feeds lock inp0.
- key1_pulse  output  1  one-cycle pulse per accepted key-1 press; feeds lock inp1.
- key_conflict  output  1  high while in CHORD state.
- key_stuck  output  1  stuck-key flag; tied 0 when feature is compiled out.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, debounced levels db0/db1, counters, FSM (IDLE) and all outputs go to 0.
  - Assertion mid-press drops any pending pulse.
  - After release, a key still held must first debounce from 0 again.
- Synchroniser: two flops per key; sync_k is the second stage.
- Debounce, per key, independent:
  - if sync_k == db_k, cnt_k <= 0;
  - else if cnt_k == DEBOUNCE_CYCLES-1, db_k <= sync_k and cnt_k <= 0;
  - else cnt_k <= cnt_k+1.
  - Any single-cycle agreement restarts the count. Release debounces identically.
- Arbitration FSM (registered; evaluates db0/db1 each cycle):
  - IDLE:
    - db0=1, db1=0 -> HELD0, key0_pulse=1 next cycle.
    - db1=1, db0=0 -> HELD1, key1_pulse=1 next cycle.
    - both 1 in the same cycle -> CHORD, no pulse.
  - HELD0:
    - db1 rises -> CHORD (key0 pulse already issued is not retracted).
    - db0=0 and db1=0 -> IDLE.
  - HELD1: mirror of HELD0.
  - CHORD: key_conflict=1; stays until db0=0 and db1=0, then IDLE. No pulses are ever emitted from CHORD.
- Pulse rules:
  - Pulses are exactly one cycle wide, at most one per debounced press.
  - key0_pulse and key1_pulse are never high together.
  - Holding a key never repeats its pulse.
- Latency: raw key held stable high from the first edge that samples it (edge 1) -> pulse high during the cycle following edge DEBOUNCE_CYCLES+3.
- Glitch rejection: a bounce shorter than DEBOUNCE_CYCLES synchronised cycles never changes db_k.

Optional Feature:
- Macro KEY_STUCK_DETECT_EN.
- Defined:
  - A 26-bit hold counter runs while state is HELD0, HELD1 or CHORD, and clears in IDLE.
  - When the count reaches STUCK_CYCLES-1, key_stuck is set.
  - key_stuck is sticky until the FSM returns to IDLE or reset is asserted.
  - key_stuck does not alter pulse generation.
- Undefined: no counter logic; key_stuck is constant 0.

Test Plan (DEBOUNCE_CYCLES=4, STUCK_CYCLES=20):
- Reset: hold reset=0 with btn0=btn1=1 -> all outputs 0; release reset with btn0 held -> exactly one key0_pulse, at edge 7 after the first sampling edge.
- Clean press: btn0 high 20 cycles, then low -> single key0_pulse, 1 cycle wide, latency 7 edges; key1_pulse stays 0.
- Bounce: btn1 toggles with 1-3 cycle highs for 30 cycles, then stays high -> no pulse during the bouncing, then exactly one key1_pulse 7 edges after the final stable rise.
- Chord, simultaneous: btn0 and btn1 rise on the same edge -> no pulses, key_conflict=1 until both are debounced low, then next single btn1 press -> one key1_pulse.
- Chord, late: btn0 press, key0_pulse seen, then btn1 press while btn0 held -> no key1_pulse, key_conflict=1; release both -> IDLE.
- Stuck (KEY_STUCK_DETECT_EN defined): hold btn0 for 40 cycles -> key_stuck rises 20 cycles after entering HELD0, clears the cycle after return to IDLE; with the macro undefined -> key_stuck stays 0.
